// File: rtl/if_id_pipe.sv
// if_id_pipe
//
// Pipeline stage between instruction fetch and decode. Carries a PC and
// instruction pair across a valid/ready handshake. A synchronous flush
// handles branch redirects. When the stage is empty, the outputs show a
// NOP bubble.
//
// Build option:
//   IF_ID_SKID_EN defined   - head register plus skid register (occ 0..2).
//                             in_ready depends only on registered state and
//                             rst, so there is no combinational path from
//                             out_ready back to fetch.
//   IF_ID_SKID_EN undefined - head register only (occ 0..1). in_ready
//                             follows out_ready combinationally.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active low; takes priority over flush
//   flush      empties the stage at the next edge; an entry offered in the
//              same cycle is dropped
//   in_valid   fetch presents an entry
//   in_ready   stage accepts the entry this cycle
//   in_pc      PC of the presented entry
//   in_inst    instruction of the presented entry
//   out_valid  head entry is valid toward decode
//   out_ready  decode consumes the head entry
//   out_pc     head PC; 0 when empty
//   out_inst   head instruction; NOP_INST when empty
//   occ        number of held entries
module if_id_pipe #(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   IW       = 32,
    parameter logic [IW-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_pc,
    input  logic [IW-1:0] in_inst,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_pc,
    output logic [IW-1:0] out_inst,
    output logic [1:0]    occ
);

    logic [AW-1:0] r_head_pc;
    logic [IW-1:0] r_head_inst;
    logic [1:0]    w_occ;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;

    assign w_out_valid = (w_occ != 2'd0);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

`ifdef IF_ID_SKID_EN
    // r_occ: 0 = empty, 1 = head only, 2 = head and skid both full.
    logic [1:0]    r_occ;
    logic [AW-1:0] r_skid_pc;
    logic [IW-1:0] r_skid_inst;

    assign w_occ      = r_occ;
    // Registered occupancy only. With occ = 2 fetch is held off, so
    // push and pop can never coincide in the full state.
    assign w_in_ready = rst & (r_occ < 2'd2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_occ <= 2'd0;
        end else if (flush) begin
            r_occ <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (w_push) r_occ <= 2'd1;
                end
                2'd1: begin
                    if (w_push && !w_pop)      r_occ <= 2'd2;
                    else if (!w_push && w_pop) r_occ <= 2'd0;
                end
                default: begin
                    if (w_pop) r_occ <= 2'd1;
                end
            endcase
        end
    end

    // The data registers have no reset. The outputs are forced whenever
    // the stage is empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            case (r_occ)
                2'd0: begin
                    if (w_push) begin
                        r_head_pc   <= in_pc;
                        r_head_inst <= in_inst;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head_pc   <= in_pc;
                        r_head_inst <= in_inst;
                    end else if (w_push) begin
                        r_skid_pc   <= in_pc;
                        r_skid_inst <= in_inst;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head_pc   <= r_skid_pc;
                        r_head_inst <= r_skid_inst;
                    end
                end
            endcase
        end
    end
`else
    logic r_valid;

    assign w_occ      = {1'b0, r_valid};
    // Combinational path from out_ready: the head can be replaced in the
    // same edge in which decode consumes it.
    assign w_in_ready = rst & (~r_valid | out_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_push) begin
            r_valid <= 1'b1;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

    // w_push is already 0 while rst is low, because in_ready is gated by rst.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_head_pc   <= in_pc;
            r_head_inst <= in_inst;
        end
    end
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign occ       = w_occ;
    assign out_pc    = w_out_valid ? r_head_pc   : '0;
    assign out_inst  = w_out_valid ? r_head_inst : NOP_INST;

endmodule

// File: tb/tb_if_id_pipe.sv
module tb_if_id_pipe;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  occ;

    ent_t q[$];
    int   n_pass;
    int   n_total;
    bit   m_pushed;

    if_id_pipe #(.AW(32), .IW(32), .NOP_INST(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0033;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit exp_ready();
`ifdef IF_ID_SKID_EN
        return rst && (q.size() < 2);
`else
        return rst && ((q.size() == 0) || out_ready);
`endif
    endfunction

    // Compares the current outputs against the scoreboard head and occupancy.
    task automatic check_state();
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        e_pc   = (q.size() != 0) ? q[0].pc   : 32'h0;
        e_inst = (q.size() != 0) ? q[0].inst : NOP;
        chk("in_ready",  64'(in_ready),  64'(exp_ready()));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("occ",       64'(occ),       64'(q.size()));
        chk("out_pc",    64'(out_pc),    64'(e_pc));
        chk("out_inst",  64'(out_inst),  64'(e_inst));
    endtask

    // Checks mid-cycle, then applies the reference handshake at the edge.
    task automatic cycle();
        bit push;
        bit pop;
        @(negedge clk);
        check_state();
        push     = in_valid && exp_ready();
        pop      = (q.size() != 0) && out_ready;
        m_pushed = 1'b0;
        if (!rst || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back('{pc: in_pc, inst: in_inst});
                m_pushed = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = mk_inst(pc);
    endtask

    // Offers pc until it is accepted; bounded so a stuck DUT cannot hang.
    task automatic send(input logic [31:0] pc);
        drive(pc);
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (m_pushed) break;
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (q.size() == 0) break;
            cycle();
        end
        cycle();
        chk("drain_empty", 64'(occ), 64'(0));
    endtask

    logic [31:0] next_pc;

    initial begin
        n_pass    = 0;
        n_total   = 0;
        m_pushed  = 1'b0;
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(32'h0000_0ABC);

        // Reset held for 3 cycles with in_valid = 1.
        repeat (3) cycle();
        rst      = 1'b1;
        in_valid = 1'b0;
        cycle();

        // Streaming: one entry per cycle, occ stays 1.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(32'(i * 4));
        drain();

        // Backpressure.
        out_ready = 1'b0;
        send(32'h100);
`ifdef IF_ID_SKID_EN
        send(32'h104);
        drive(32'h108);
        cycle();
        cycle();
        out_ready = 1'b1;
        send(32'h108);
`else
        drive(32'h104);
        cycle();
        cycle();
        out_ready = 1'b1;
        #1;
        chk("rdy_comb_up", 64'(in_ready), 64'(1));
        out_ready = 1'b0;
        #1;
        chk("rdy_comb_dn", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        send(32'h104);
        chk("replace_occ", 64'(occ), 64'(1));
        chk("replace_pc", 64'(out_pc), 64'(32'h104));
`endif
        drain();

        // Flush while holding entries and offering a new one.
        out_ready = 1'b0;
        send(32'h180);
`ifdef IF_ID_SKID_EN
        send(32'h184);
`endif
        flush = 1'b1;
        drive(32'h200);
        cycle();
        // Empty stage with in_ready = 1: the offer is still dropped, twice.
        drive(32'h204);
        cycle();
        cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        cycle();
        out_ready = 1'b1;
        send(32'h300);
        drain();

        // Reset mid-stream.
        out_ready = 1'b0;
        send(32'h400);
`ifdef IF_ID_SKID_EN
        send(32'h404);
`endif
        in_valid = 1'b0;
        rst      = 1'b0;
        cycle();
        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (3) cycle();
        send(32'h500);
        drain();

        // Mixed traffic with random stalls.
        next_pc = 32'h1000;
        for (int i = 0; i < 60; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            drive(next_pc);
            in_valid = 1'($urandom_range(0, 1));
            cycle();
            if (m_pushed) next_pc = next_pc + 32'd4;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Handshaked pipeline stage between instruction fetch and decode. It carries a PC/instruction pair from fetch to decode with a valid/ready handshake, a synchronous flush for branch redirects, and a NOP bubble on its outputs whenever it is empty. It generalises the hold/default-value pipeline flop into a buffered stage, so fetch can stall without a combinational ready path back from decode.

## Interface
Parameters:
- `AW`, 32, PC width.
- `IW`, 32, instruction width.
- `NOP_INST`, 32'h0000_0013, instruction driven on `out_inst` when the stage is empty (RV32 `addi x0,x0,0`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `flush`  in  1  discard all held entries; takes effect at the next edge.
- `in_valid`  in  1  fetch presents an entry.
- `in_ready`  out  1  stage can accept an entry.
- `in_pc`  in  AW  PC of the presented entry.
- `in_inst`  in  IW  instruction of the presented entry.
- `out_valid`  out  1  head entry valid toward decode.
- `out_ready`  in  1  decode consumes the head entry.
- `out_pc`  out  AW  head PC; 0 when empty.
- `out_inst`  out  IW  head instruction; `NOP_INST` when empty.
- `occ`  out  2  number of held entries (0..2).

## Operation
- Push on a cycle with `in_valid & in_ready`. Pop on a cycle with `out_valid & out_ready`. Entries are strictly FIFO-ordered.
- Storage is a head register plus a skid register (see Configuration). `occ` is registered.
- `in_ready` = `rst & (occ < 2)`. It is derived only from registered state and `rst`, with no path from `out_ready`.
- `out_valid` = `occ != 0`.
- Empty outputs are forced: `out_pc` = 0 and `out_inst` = `NOP_INST`.
- Push and pop together:
  - `occ` = 1: the new entry becomes the head; `occ` stays 1.
  - `occ` = 2: cannot occur, because `in_ready` = 0.
- Push into an empty stage: the entry becomes the head.
- Push with `occ` = 1 and no pop: the entry goes to the skid register; `occ` = 2.
- Pop with `occ` = 2: the skid entry moves to the head; `occ` = 1.
- Stability: while `out_valid & !out_ready`, `out_pc` and `out_inst` do not change.
- `flush` has priority over push and pop. At the next edge `occ` = 0, and any entry offered in the flush cycle is dropped, even if `in_ready` = 1. Fetch treats that handshake as complete and discards the entry.
- Reset has priority over `flush`.

## Timing
- Reset values: `occ` = 0, `out_valid` = 0, `out_pc` = 0, `out_inst` = `NOP_INST`, `in_ready` = 0 while `rst` = 0.
- `in_ready` = 1 in the first cycle after `rst` rises.
- Latency: an entry pushed at edge N is visible on `out_*` with `out_valid` = 1 in the cycle following edge N.
- Throughput: one entry per cycle while `out_ready` = 1.
- Fill behaviour: after `out_ready` drops, the stage absorbs exactly 2 entries; `in_ready` goes low in the cycle after the second push.
- Reset asserted mid-operation clears all state at that edge. Entries held at that point are lost and no handshake completes while `rst` = 0.
- `flush` asserted for consecutive cycles keeps the stage empty.

## Configuration
- Macro: `IF_ID_SKID_EN`.
- Defined: the 2-entry skid buffer described above, with registered `in_ready`; `occ` ranges 0..2.
- Undefined: no skid register.
  - `in_ready` = `rst & (!out_valid | out_ready)`, a combinational path from `out_ready`.
  - `occ` ranges 0..1, and `occ[1]` is tied to 0.
  - Push with pop replaces the head in the same edge.
  - Flush, reset, empty-output and stability rules are unchanged.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles with `in_valid` = 1 → `in_ready` = 0, `out_valid` = 0, `out_inst` = 32'h13, `out_pc` = 0. After release, `in_ready` = 1.
- **Streaming:** push PCs 0x0, 0x4, 0x8, … on consecutive cycles with `out_ready` = 1 → each appears one cycle later, in order, with no gaps; `occ` stays 1.
- **Backpressure (skid):** set `out_ready` = 0 and push 0x100, 0x104, 0x108 → 0x100 and 0x104 are accepted, `occ` = 2, `in_ready` = 0, and 0x108 is held by fetch. Then set `out_ready` = 1 → outputs are 0x100, 0x104, 0x108 in order.
- **Flush:** with `occ` = 2, assert `flush` while pushing 0x200 → next cycle `occ` = 0, `out_inst` = NOP, and 0x200 never appears. A push of 0x300 on the following cycle appears normally.
- **Reset mid-stream:** with `occ` = 2, pull `rst` low for 1 cycle → all outputs return to reset values and none of the held entries appear afterwards.
- **Non-skid build:** with `IF_ID_SKID_EN` undefined, hold `out_ready` = 0 after one push → `in_ready` = 0 in the same cycle. Raising `out_ready` makes `in_ready` = 1 combinationally, and push and pop complete at the same edge.
